// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD result serial transmitter.
// State encodings, line idle level and a width helper.
package gcd_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } tx_state_t;

  // ceil(log2(v)), never below 1 so counters keep a real bit
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period down-counter for the serial transmitter.
// Emits bit_tick in the last cycle of each BIT_CYCLES-long bit.
module tx_bit_timer
  import gcd_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic bit_tick
);

  localparam int TW = clog2(BIT_CYCLES);
  localparam logic [TW-1:0] RELOAD = TW'(BIT_CYCLES - 1);

  logic [TW-1:0] cnt;

  assign bit_tick = en && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load || bit_tick) begin
      cnt <= RELOAD;
    end else if (en) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/gcd_result_serial_tx.sv
// UART-style framer for the GCD result word.
// Start low, WIDTH data bits, stop high; all outputs registered.
module gcd_result_serial_tx
  import gcd_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             tx_out,
  output logic             busy,
  output logic             done
);

  localparam int IW = clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  tx_state_t        state;
  tx_state_t        state_n;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_n;
  logic [WIDTH-1:0] shifted;
  logic [IW-1:0]    bit_idx;
  logic [IW-1:0]    bit_idx_n;
  logic             tx_n;
  logic             done_n;
  logic             accept;
  logic             tmr_en;
  logic             bit_tick;

  function automatic logic head(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  assign accept = (state == IDLE) && in_valid;
  assign tmr_en = (state != IDLE);

  tx_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .en      (tmr_en),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_idx_n = bit_idx;
    tx_n      = tx_out;
    done_n    = 1'b0;
    shifted   = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
    unique case (state)
      IDLE: begin
        tx_n = IDLE_LEVEL;
        if (in_valid) begin
          state_n = START;
          shreg_n = in_data;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (bit_tick) begin
          state_n   = DATA;
          bit_idx_n = '0;
          tx_n      = head(shreg);
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_idx == LAST) begin
            state_n = STOP;
            tx_n    = IDLE_LEVEL;
          end else begin
            shreg_n   = shifted;
            bit_idx_n = bit_idx + 1'b1;
            tx_n      = head(shifted);
          end
        end
      end
      STOP: begin
        if (bit_tick) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // busy/in_ready follow the next state so they line up with tx_out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      tx_out   <= IDLE_LEVEL;
      busy     <= 1'b0;
      in_ready <= 1'b1;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bit_idx  <= bit_idx_n;
      tx_out   <= tx_n;
      busy     <= (state_n != IDLE);
      in_ready <= (state_n == IDLE);
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_gcd_result_serial_tx.sv
// Bench for gcd_result_serial_tx: three configurations
// checked cycle by cycle against a frame-level model.
module tb_gcd_result_serial_tx;

  logic       clk;
  logic       rst_n;
  logic [2:0] vld;
  logic [7:0] dat0;
  logic [7:0] dat1;
  logic [0:0] dat2;
  logic [2:0] rdy;
  logic [2:0] tx;
  logic [2:0] bsy;
  logic [2:0] dn;

  int checks;
  int errors;
  bit exp_q[$];

  gcd_result_serial_tx #(.WIDTH(8), .BIT_CYCLES(1), .MSB_FIRST(1'b0)) d0 (
    .clk(clk), .rst_n(rst_n), .in_data(dat0), .in_valid(vld[0]),
    .in_ready(rdy[0]), .tx_out(tx[0]), .busy(bsy[0]), .done(dn[0])
  );

  gcd_result_serial_tx #(.WIDTH(8), .BIT_CYCLES(4), .MSB_FIRST(1'b1)) d1 (
    .clk(clk), .rst_n(rst_n), .in_data(dat1), .in_valid(vld[1]),
    .in_ready(rdy[1]), .tx_out(tx[1]), .busy(bsy[1]), .done(dn[1])
  );

  gcd_result_serial_tx #(.WIDTH(1), .BIT_CYCLES(1), .MSB_FIRST(1'b0)) d2 (
    .clk(clk), .rst_n(rst_n), .in_data(dat2), .in_valid(vld[2]),
    .in_ready(rdy[2]), .tx_out(tx[2]), .busy(bsy[2]), .done(dn[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask

  task automatic set_in(input int d, input logic v, input logic [7:0] w);
    case (d)
      0: begin vld[0] = v; dat0 = w; end
      1: begin vld[1] = v; dat1 = w; end
      default: begin vld[2] = v; dat2 = w[0]; end
    endcase
  endtask

  // Expected line level per cycle of a whole frame
  task automatic build(input int d, input logic [7:0] w);
    int wd;
    int bc;
    bit msb;
    int idx;
    case (d)
      0: begin wd = 8; bc = 1; msb = 1'b0; end
      1: begin wd = 8; bc = 4; msb = 1'b1; end
      default: begin wd = 1; bc = 1; msb = 1'b0; end
    endcase
    exp_q.delete();
    repeat (bc) exp_q.push_back(1'b0);
    for (int i = 0; i < wd; i++) begin
      idx = msb ? (wd - 1 - i) : i;
      repeat (bc) exp_q.push_back(w[idx]);
    end
    repeat (bc) exp_q.push_back(1'b1);
  endtask

  task automatic check_idle(input int d, input logic exp_done);
    chk($sformatf("d%0d idle tx", d), tx[d], 1'b1);
    chk($sformatf("d%0d idle busy", d), bsy[d], 1'b0);
    chk($sformatf("d%0d idle rdy", d), rdy[d], 1'b1);
    chk($sformatf("d%0d idle done", d), dn[d], exp_done);
  endtask

  // Called at a negedge with the DUT ready; returns at the done cycle
  task automatic run_frame(input int d, input logic [7:0] w,
                           input bit keep);
    chk($sformatf("d%0d ready before send", d), rdy[d], 1'b1);
    set_in(d, 1'b1, w);
    build(d, w);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      set_in(d, keep, 8'($urandom));
      chk($sformatf("d%0d w%02h c%0d tx", d, w, i), tx[d], exp_q[i]);
      chk($sformatf("d%0d w%02h c%0d busy", d, w, i), bsy[d], 1'b1);
      chk($sformatf("d%0d w%02h c%0d rdy", d, w, i), rdy[d], 1'b0);
      chk($sformatf("d%0d w%02h c%0d done", d, w, i), dn[d], 1'b0);
    end
    @(negedge clk);
    check_idle(d, 1'b1);
    if (!keep) set_in(d, 1'b0, 8'($urandom));
  endtask

  task automatic idle(input int d, input int n);
    repeat (n) begin
      @(negedge clk);
      check_idle(d, 1'b0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    vld    = 3'b111;
    dat0   = 8'($urandom);
    dat1   = 8'($urandom);
    dat2   = 1'($urandom);

    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) check_idle(d, 1'b0);
    rst_n = 1'b1;
    vld   = 3'b000;

    run_frame(0, 8'hA5, 1'b0);
    idle(0, 2);

    run_frame(1, 8'h3C, 1'b0);
    idle(1, 2);

    run_frame(0, 8'h00, 1'b1);
    run_frame(0, 8'hFF, 1'b0);
    idle(0, 2);

    run_frame(2, 8'h00, 1'b0);
    idle(2, 2);
    run_frame(2, 8'h01, 1'b0);
    idle(2, 1);

    for (int k = 0; k < 8; k++) begin
      int d;
      d = $urandom_range(0, 2);
      run_frame(d, 8'($urandom), 1'b0);
      idle(d, $urandom_range(1, 3));
    end

    // Abort in the middle of data bit 3 of 0x55
    chk("abort ready", rdy[0], 1'b1);
    set_in(0, 1'b1, 8'h55);
    @(negedge clk);
    set_in(0, 1'b0, 8'($urandom));
    repeat (4) @(negedge clk);
    chk("abort bit3 tx", tx[0], 1'b0);
    chk("abort bit3 busy", bsy[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort async tx", tx[0], 1'b1);
    chk("abort async busy", bsy[0], 1'b0);
    chk("abort async rdy", rdy[0], 1'b1);
    chk("abort async done", dn[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(0, 8'h81, 1'b0);
    idle(0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
